// File: rtl/sched_pkg.sv
// Shared types and constants for the nonce dispatch scheduler.
// Imported by the interface, the arbiter and the scheduler top.
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_e;

    localparam int MAX_CORES   = 8;
    localparam int CORE_IDX_W  = $clog2(MAX_CORES);
    localparam int DEF_NONCE_W = 32;

    // Result slot address; 16-bit arithmetic wraps past 16'hFFFF.
    function automatic logic [15:0] result_addr(
        input logic [15:0] base,
        input logic [15:0] offset
    );
        return base + offset;
    endfunction

endpackage

// File: rtl/nonce_dispatch_scheduler_if.sv
// Core-side and memory-side bundle of the nonce dispatch scheduler.
// master = scheduler, slave = hash cores plus result memory.
interface nonce_dispatch_scheduler_if
    import sched_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = DEF_NONCE_W
) ();

    logic [NUM_CORES-1:0]    core_start;
    logic [NONCE_W-1:0]      core_nonce;
    logic [NUM_CORES-1:0]    core_done;
    logic [32*NUM_CORES-1:0] core_h0;
    logic                    mem_we;
    logic [15:0]             mem_addr;
    logic [31:0]             mem_write_data;

    modport master (
        output core_start,
        output core_nonce,
        input  core_done,
        input  core_h0,
        output mem_we,
        output mem_addr,
        output mem_write_data
    );

    modport slave (
        input  core_start,
        input  core_nonce,
        output core_done,
        output core_h0,
        input  mem_we,
        input  mem_addr,
        input  mem_write_data
    );

endinterface

// File: rtl/nonce_dispatch_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority rotates past the
// last granted requester whenever advance is high.
module rr_arbiter
    import sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    logic [CORE_IDX_W-1:0] last_q;
    logic [CORE_IDX_W-1:0] last_d;
    logic [CORE_IDX_W-1:0] pick;
    logic [N-1:0]          above;
    logic [N-1:0]          masked;
    logic [N-1:0]          cand;
    logic                  found;

    always_comb begin
        above = '0;
        for (int i = 0; i < N; i++) begin
            above[i] = (i > int'(last_q));
        end
        masked = req & above;
        // Wrap to the bottom when nothing sits above the last grant.
        cand  = (|masked) ? masked : req;
        grant = '0;
        pick  = last_q;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && cand[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                pick     = CORE_IDX_W'(i);
            end
        end
        last_d = (advance && found) ? pick : last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= CORE_IDX_W'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/nonce_dispatch_scheduler.sv
// Shares NUM_CORES double-SHA cores over one nonce sweep: dispatches
// nonces to idle cores, captures H0 results, serialises memory writes.
module nonce_dispatch_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int NONCE_W   = DEF_NONCE_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [15:0]               output_addr,
    input  logic [NONCE_W-1:0]        nonce_count,
    nonce_dispatch_scheduler_if.master bus,
    output logic                      busy,
    output logic                      done
);

    state_e               state_q, state_d;
    logic [NONCE_W-1:0]   next_nonce_q, next_nonce_d;
    logic [NONCE_W-1:0]   count_q, count_d;
    logic [15:0]          base_q, base_d;
    logic [NUM_CORES-1:0] core_busy_q, core_busy_d;
    logic [NUM_CORES-1:0] res_valid_q, res_valid_d;
    logic [NONCE_W-1:0]   res_nonce_q [NUM_CORES];
    logic [NONCE_W-1:0]   res_nonce_d [NUM_CORES];
    logic [31:0]          res_h0_q [NUM_CORES];
    logic [31:0]          res_h0_d [NUM_CORES];

    logic [NUM_CORES-1:0] core_start_q, core_start_d;
    logic [NONCE_W-1:0]   core_nonce_q, core_nonce_d;
    logic                 mem_we_q, mem_we_d;
    logic [15:0]          mem_addr_q, mem_addr_d;
    logic [31:0]          mem_write_data_q, mem_write_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [NUM_CORES-1:0] wb_grant;
    logic                 wb_advance;
    logic                 disp_found;

    assign wb_advance = (state_q == RUN);

    rr_arbiter #(
        .N (NUM_CORES)
    ) u_wb_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (res_valid_q),
        .advance (wb_advance),
        .grant   (wb_grant)
    );

    always_comb begin
        state_d          = state_q;
        next_nonce_d     = next_nonce_q;
        count_d          = count_q;
        base_d           = base_q;
        core_busy_d      = core_busy_q;
        res_valid_d      = res_valid_q;
        res_nonce_d      = res_nonce_q;
        res_h0_d         = res_h0_q;
        core_start_d     = '0;
        core_nonce_d     = core_nonce_q;
        mem_we_d         = 1'b0;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        busy_d           = busy_q;
        done_d           = done_q;
        disp_found       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d       = output_addr;
                    count_d      = nonce_count;
                    next_nonce_d = '0;
                    core_busy_d  = '0;
                    res_valid_d  = '0;
                    done_d       = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (bus.core_done[i] && core_busy_q[i]) begin
                        res_h0_d[i]    = bus.core_h0[i*32 +: 32];
                        res_valid_d[i] = 1'b1;
                        core_busy_d[i] = 1'b0;
                    end
                end
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (wb_grant[i]) begin
                        mem_we_d         = 1'b1;
                        mem_addr_d       = result_addr(base_q, 16'(res_nonce_q[i]));
                        mem_write_data_d = res_h0_q[i];
                        res_valid_d[i]   = 1'b0;
                    end
                end
                // Registered flags keep a just-granted core out until next cycle.
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (!disp_found && !core_busy_q[i] && !res_valid_q[i]
                        && (next_nonce_q < count_q)) begin
                        disp_found      = 1'b1;
                        core_start_d[i] = 1'b1;
                        core_nonce_d    = next_nonce_q;
                        core_busy_d[i]  = 1'b1;
                        res_nonce_d[i]  = next_nonce_q;
                    end
                end
                if (disp_found) begin
                    next_nonce_d = next_nonce_q + 1'b1;
                end
                if ((next_nonce_q == count_q) && (core_busy_q == '0)
                    && (res_valid_q == '0)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            next_nonce_q     <= '0;
            count_q          <= '0;
            base_q           <= '0;
            core_busy_q      <= '0;
            res_valid_q      <= '0;
            res_nonce_q      <= '{default: '0};
            res_h0_q         <= '{default: '0};
            core_start_q     <= '0;
            core_nonce_q     <= '0;
            mem_we_q         <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            next_nonce_q     <= next_nonce_d;
            count_q          <= count_d;
            base_q           <= base_d;
            core_busy_q      <= core_busy_d;
            res_valid_q      <= res_valid_d;
            res_nonce_q      <= res_nonce_d;
            res_h0_q         <= res_h0_d;
            core_start_q     <= core_start_d;
            core_nonce_q     <= core_nonce_d;
            mem_we_q         <= mem_we_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign bus.core_start     = core_start_q;
    assign bus.core_nonce     = core_nonce_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_write_data_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule
